// File: rtl/booth_csa_mul_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier:
// FSM state codes, Booth digit codes and the digit-count helper.
package booth_csa_mul_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RESOLVE = 2'd2,
      DONE    = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      ZERO = 3'd0,
      POS1 = 3'd1,
      POS2 = 3'd2,
      NEG1 = 3'd3,
      NEG2 = 3'd4
   } digit_t;

   function automatic int DigitCount(input int dataWidth);
      return (dataWidth + 2) / 2;
   endfunction

   // Window is {b[2i+1], b[2i], b[2i-1]}.
   function automatic digit_t DecodeDigit(input logic [2:0] window);
      digit_t digit;
      case (window)
         3'b001, 3'b010: digit = POS1;
         3'b011:         digit = POS2;
         3'b100:         digit = NEG2;
         3'b101, 3'b110: digit = NEG1;
         default:        digit = ZERO;
      endcase
      return digit;
   endfunction

endpackage

// File: rtl/booth_csa_mul_csa.sv
// 3:2 carry-save adder: compresses three vectors into a sum and a carry
// vector whose modular sum equals the sum of the inputs.
module CasAdder3_2 #(
   parameter int DataWidth = 128
) (
   input  logic [DataWidth-1:0] InA,
   input  logic [DataWidth-1:0] InB,
   input  logic [DataWidth-1:0] InC,
   output logic [DataWidth-1:0] Sum,
   output logic [DataWidth-1:0] Carry
);

   logic [DataWidth-1:0] majority;

   assign Sum      = InA ^ InB ^ InC;
   assign majority = (InA & InB) | (InA & InC) | (InB & InC);
   assign Carry    = majority << 1;

endmodule

// File: rtl/booth_csa_mul_pp_encoder.sv
// Radix-4 Booth partial-product generator: turns one 3-bit multiplier window
// into digit*A, sign-extended to the full product width and shifted into place.
module booth_pp_encoder
   import booth_csa_mul_pkg::*;
#(
   parameter int DataWidth  = 64,
   parameter int IndexWidth = 6
) (
   input  logic [2:0]             Window,
   input  logic [DataWidth+1:0]   AExt,
   input  logic [IndexWidth-1:0]  Index,
   output logic [2*DataWidth-1:0] Pp
);

   localparam int ExtWidth  = DataWidth + 2;
   localparam int ProdWidth = 2 * DataWidth;

   digit_t               digit;
   logic [ProdWidth-1:0] aWide;
   logic [ProdWidth-1:0] magnitude;
   logic [ProdWidth-1:0] signedPp;

   // Negation is a full two's complement of the widened value, so no
   // separate +1 injection bit is needed downstream.
   always_comb begin
      digit = DecodeDigit(Window);
      aWide = {{(ProdWidth - ExtWidth){AExt[ExtWidth-1]}}, AExt};
      case (digit)
         POS1, NEG1: magnitude = aWide;
         POS2, NEG2: magnitude = aWide << 1;
         default:    magnitude = '0;
      endcase
      signedPp = ((digit == NEG1) || (digit == NEG2)) ? -magnitude : magnitude;
      Pp       = signedPp << {Index, 1'b0};
   end

endmodule

// File: rtl/booth_csa_mul.sv
// Iterative radix-4 Booth multiplier: one partial product per cycle into a
// carry-save accumulator, then a single carry-propagate add for the product.
module booth_csa_mul
   import booth_csa_mul_pkg::*;
#(
   parameter int DataWidth = 64
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   Flush,
   input  logic                   InValid,
   output logic                   InReady,
   input  logic [DataWidth-1:0]   Multiplicand,
   input  logic [DataWidth-1:0]   Multiplier,
   input  logic                   SignA,
   input  logic                   SignB,
   output logic                   OutValid,
   input  logic                   OutReady,
   output logic [2*DataWidth-1:0] Product
);

   localparam int ExtWidth  = DataWidth + 2;
   localparam int ProdWidth = 2 * DataWidth;
   localparam int NumDigits = DigitCount(DataWidth);
   localparam int CntWidth  = $clog2(NumDigits);

   state_t               state;
   logic [ExtWidth-1:0]  aExt;
   logic [ExtWidth-1:0]  bExt;
   logic [ProdWidth-1:0] sumReg;
   logic [ProdWidth-1:0] carryReg;
   logic [CntWidth-1:0]  cnt;
   logic [ExtWidth:0]    bWindowSrc;
   logic [2:0]           window;
   logic [ProdWidth-1:0] pp;
   logic [ProdWidth-1:0] csaSum;
   logic [ProdWidth-1:0] csaCarry;
   logic                 lastDigit;

   // The appended zero supplies the implicit b[-1] for the first window.
   assign bWindowSrc = {bExt, 1'b0};
   assign window     = 3'(bWindowSrc >> {cnt, 1'b0});
   assign lastDigit  = (cnt == CntWidth'(NumDigits - 1));

   booth_pp_encoder #(
      .DataWidth (DataWidth),
      .IndexWidth(CntWidth)
   ) ppEncoder (
      .Window(window),
      .AExt  (aExt),
      .Index (cnt),
      .Pp    (pp)
   );

   CasAdder3_2 #(
      .DataWidth(ProdWidth)
   ) csa (
      .InA  (sumReg),
      .InB  (carryReg),
      .InC  (pp),
      .Sum  (csaSum),
      .Carry(csaCarry)
   );

   // Control FSM with registered handshake outputs; Flush outranks any
   // handshake in the same cycle.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state    <= IDLE;
         InReady  <= 1'b1;
         OutValid <= 1'b0;
         Product  <= '0;
         aExt     <= '0;
         bExt     <= '0;
         sumReg   <= '0;
         carryReg <= '0;
         cnt      <= '0;
      end else if (Flush) begin
         state    <= IDLE;
         InReady  <= 1'b1;
         OutValid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (InValid && InReady) begin
                  aExt     <= {{2{SignA & Multiplicand[DataWidth-1]}}, Multiplicand};
                  bExt     <= {{2{SignB & Multiplier[DataWidth-1]}}, Multiplier};
                  sumReg   <= '0;
                  carryReg <= '0;
                  cnt      <= '0;
                  InReady  <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               sumReg   <= csaSum;
               carryReg <= csaCarry;
               cnt      <= cnt + CntWidth'(1);
               if (lastDigit) begin
                  state <= RESOLVE;
               end
            end
            RESOLVE: begin
               Product  <= sumReg + carryReg;
               OutValid <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               if (OutReady) begin
                  OutValid <= 1'b0;
                  InReady  <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Each BUSY step must add exactly one partial product to the redundant pair.
   assert property (@(posedge Clk) disable iff (!Rst)
      (state == BUSY) |-> ((csaSum + csaCarry) == (sumReg + carryReg + pp)));

endmodule

// File: tb/tb_booth_csa_mul.sv
// Self-checking bench for booth_csa_mul: directed corner products, handshake,
// flush and reset behaviour, then a randomized regression against A*B.
module tb_booth_csa_mul;

   localparam int DataWidth = 64;
   localparam int ProdWidth = 2 * DataWidth;
   localparam int NumDigits = (DataWidth + 2) / 2;
   // OutValid rises in cycle N+2 when the accept cycle is cycle 0,
   // i.e. N+1 rising edges after the accepting edge.
   localparam int Latency   = NumDigits + 1;

   typedef logic [ProdWidth-1:0] wide_t;

   logic                 Clk = 1'b0;
   logic                 Rst = 1'b0;
   logic                 Flush = 1'b0;
   logic                 InValid = 1'b0;
   logic                 InReady;
   logic [DataWidth-1:0] Multiplicand = '0;
   logic [DataWidth-1:0] Multiplier = '0;
   logic                 SignA = 1'b0;
   logic                 SignB = 1'b0;
   logic                 OutValid;
   logic                 OutReady = 1'b0;
   wide_t                Product;

   wide_t expQ[$];
   int    assertCount = 0;
   int    failCount = 0;
   int    cycleCount = 0;
   int    acceptCycle = 0;

   booth_csa_mul #(
      .DataWidth(DataWidth)
   ) dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Flush       (Flush),
      .InValid     (InValid),
      .InReady     (InReady),
      .Multiplicand(Multiplicand),
      .Multiplier  (Multiplier),
      .SignA       (SignA),
      .SignB       (SignB),
      .OutValid    (OutValid),
      .OutReady    (OutReady),
      .Product     (Product)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cycleCount <= cycleCount + 1;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input wide_t observed, input wide_t expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   function automatic wide_t refProduct(input logic [DataWidth-1:0] a, input logic [DataWidth-1:0] b,
                                        input logic sa, input logic sb);
      wide_t aw;
      wide_t bw;
      aw = {{DataWidth{sa & a[DataWidth-1]}}, a};
      bw = {{DataWidth{sb & b[DataWidth-1]}}, b};
      return aw * bw;
   endfunction

   function automatic logic [DataWidth-1:0] pickOperand();
      logic [DataWidth-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b1, {(DataWidth-1){1'b0}}};
         3:       v = {{(DataWidth-1){1'b0}}, 1'b1};
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic applyStimulus(input logic [DataWidth-1:0] a, input logic [DataWidth-1:0] b,
                                input logic sa, input logic sb, input wide_t expected);
      int waited = 0;
      while (!InReady && waited < 100) begin
         @(negedge Clk);
         waited++;
      end
      checkOutput("inready_before_issue", wide_t'(InReady), wide_t'(1));
      Multiplicand = a;
      Multiplier   = b;
      SignA        = sa;
      SignB        = sb;
      InValid      = 1'b1;
      expQ.push_back(expected);
      @(negedge Clk);
      InValid     = 1'b0;
      acceptCycle = cycleCount;
   endtask

   task automatic waitResult(input string tag);
      int    waited = 0;
      wide_t expected;
      while (!OutValid && waited < 200) begin
         @(negedge Clk);
         waited++;
      end
      checkOutput({tag, "_outvalid"}, wide_t'(OutValid), wide_t'(1));
      if (OutValid) begin
         checkOutput({tag, "_latency"}, wide_t'(cycleCount - acceptCycle), wide_t'(Latency));
         if (expQ.size() == 0) begin
            checkOutput({tag, "_unexpected"}, wide_t'(OutValid), wide_t'(0));
         end else begin
            expected = expQ.pop_front();
            checkOutput(tag, Product, expected);
         end
      end
   endtask

   task automatic releaseResult();
      OutReady = 1'b1;
      @(negedge Clk);
      OutReady = 1'b0;
   endtask

   initial begin
      wide_t                heldProduct;
      logic [DataWidth-1:0] ra;
      logic [DataWidth-1:0] rb;
      logic                 rsa;
      logic                 rsb;

      // Reset values while Rst is held low.
      repeat (2) @(negedge Clk);
      checkOutput("reset_inready", wide_t'(InReady), wide_t'(1));
      checkOutput("reset_outvalid", wide_t'(OutValid), wide_t'(0));
      checkOutput("reset_product", Product, wide_t'(0));
      Rst = 1'b1;
      @(negedge Clk);

      $display("[TB] directed corner products");
      applyStimulus('1, '1, 1'b1, 1'b1, wide_t'(1));
      waitResult("neg1_x_neg1");
      releaseResult();

      applyStimulus('1, '1, 1'b0, 1'b0, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
      waitResult("umax_x_umax");
      releaseResult();

      applyStimulus(64'h8000_0000_0000_0000, 64'd2, 1'b1, 1'b0,
                    128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000);
      waitResult("mulhsu_minneg_x_2");
      releaseResult();

      applyStimulus(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
                    128'h4000_0000_0000_0000_0000_0000_0000_0000);
      waitResult("minneg_x_minneg");
      releaseResult();

      $display("[TB] back-pressure with ignored operands in DONE");
      applyStimulus(-64'sd7, 64'd9, 1'b1, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFC1);
      waitResult("neg7_x_9");
      heldProduct = Product;
      for (int i = 0; i < 10; i++) begin
         InValid      = 1'b1;
         Multiplicand = {$urandom, $urandom};
         Multiplier   = {$urandom, $urandom};
         @(negedge Clk);
         checkOutput("stall_outvalid", wide_t'(OutValid), wide_t'(1));
         checkOutput("stall_product", Product, heldProduct);
         checkOutput("stall_inready", wide_t'(InReady), wide_t'(0));
      end
      InValid = 1'b0;
      releaseResult();
      checkOutput("release_outvalid", wide_t'(OutValid), wide_t'(0));
      checkOutput("release_inready", wide_t'(InReady), wide_t'(1));
      @(negedge Clk);
      checkOutput("release_no_accept", wide_t'(InReady), wide_t'(1));

      $display("[TB] flush beats an accept in IDLE");
      Flush   = 1'b1;
      InValid = 1'b1;
      @(negedge Clk);
      Flush   = 1'b0;
      InValid = 1'b0;
      checkOutput("flush_blocks_accept", wide_t'(InReady), wide_t'(1));

      $display("[TB] flush in BUSY then new operation");
      applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, '0);
      void'(expQ.pop_back());
      repeat (11) @(negedge Clk);
      Flush = 1'b1;
      @(negedge Clk);
      Flush = 1'b0;
      checkOutput("flush_outvalid", wide_t'(OutValid), wide_t'(0));
      checkOutput("flush_inready", wide_t'(InReady), wide_t'(1));
      applyStimulus(64'd3, 64'd5, 1'b0, 1'b0, wide_t'(15));
      waitResult("post_flush_3x5");
      releaseResult();

      $display("[TB] asynchronous reset mid-BUSY");
      applyStimulus(64'hDEAD_BEEF_0000_0001, 64'h7, 1'b1, 1'b0, '0);
      void'(expQ.pop_back());
      repeat (5) @(negedge Clk);
      Rst = 1'b0;
      #1;
      checkOutput("async_rst_outvalid", wide_t'(OutValid), wide_t'(0));
      checkOutput("async_rst_inready", wide_t'(InReady), wide_t'(1));
      checkOutput("async_rst_product", Product, wide_t'(0));
      @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);

      $display("[TB] random regression, all sign modes");
      for (int i = 0; i < 300; i++) begin
         ra  = pickOperand();
         rb  = pickOperand();
         rsa = i[0];
         rsb = i[1];
         applyStimulus(ra, rb, rsa, rsb, refProduct(ra, rb, rsa, rsb));
         waitResult("random");
         repeat ($urandom_range(0, 2)) @(negedge Clk);
         releaseResult();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
